// File: rtl/main_control_fsm.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and counts retired instructions.
module main_control_fsm #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 illegal,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctl;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                ctl.alu_src_b  = 2'b10;
                ctl.result_src = 2'b10;
                ctl.ir_write   = mem_ready;
                ctl.pc_write   = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target from old PC + immediate
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default: begin
                        state_d     = FETCH;
                        ctl.illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                ctl.adr_src = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ctl.result_src = 2'b01;
                ctl.reg_write  = 1'b1;
                state_d        = FETCH;
                retire         = 1'b1;
            end
            MEMWRITE: begin
                ctl.adr_src   = 1'b1;
                ctl.mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXECR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_op    = 2'b10;
                state_d       = ALUWB;
            end
            EXECI: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                ctl.alu_op    = 2'b10;
                state_d       = ALUWB;
            end
            ALUWB: begin
                ctl.reg_write = 1'b1;
                state_d       = FETCH;
                retire        = 1'b1;
            end
            JAL: begin
                // PC takes the target computed in DECODE; ALU forms the link PC+4
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                ctl.pc_write  = 1'b1;
                state_d       = ALUWB;
            end
            BEQ: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_op    = 2'b01;
                ctl.pc_write  = zero;
                state_d       = FETCH;
                retire        = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign pc_write   = ctl.pc_write;
    assign adr_src    = ctl.adr_src;
    assign mem_write  = ctl.mem_write;
    assign ir_write   = ctl.ir_write;
    assign result_src = ctl.result_src;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign reg_write  = ctl.reg_write;
    assign illegal    = ctl.illegal;
    assign state      = state_q;
endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle main controller for the RV32I core. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects, write enables and the 2-bit `alu_op` consumed by the ALU decoder. It includes a memory-ready handshake and a retired-instruction counter. It sits between the instruction register opcode field and the datapath and ALU decoder.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode field from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `mem_write`  out  1  data memory write strobe.
- `ir_write`  out  1  instruction register and old-PC enable.
- `result_src`  out  2  result select: 00 = ALU-out register, 01 = memory data, 10 = ALU result.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op`  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- `reg_write`  out  1  register file write enable.
- `illegal`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `state`  out  4  current state encoding, for debug.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11–15 are unreachable; if entered, go to FETCH.
- Outputs are combinational from `state`, `mem_ready` and `zero`. Any signal not listed for a state is 0.
- FETCH: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. `ir_write` and `pc_write` are asserted only when `mem_ready`=1. The FSM stays in FETCH while `mem_ready`=0; otherwise it goes to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch target). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → FETCH, with `illegal`=1 for this cycle.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next state is MEMREAD if `op`=0000011, else MEMWRITE.
- MEMREAD: `adr_src`=1, `result_src`=00. Holds until `mem_ready`=1, then goes to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Next state FETCH.
- MEMWRITE: `adr_src`=1, `result_src`=00, `mem_write`=1 for the whole time in this state. Holds until `mem_ready`=1, then goes to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next state ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next state ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Next state FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1. Next state ALUWB.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=`zero`. Next state FETCH.
- `instret` increments by 1 on each transition into FETCH from MEMWB, ALUWB, BEQ, or MEMWRITE (only when `mem_ready`=1).
  - Illegal opcodes and the reset entry into FETCH do not count.
  - The counter wraps from all-ones to 0.

## Timing
- Reset (`rst_n`=0, asynchronous): `state` becomes FETCH and `instret` becomes 0 immediately. During reset all outputs are the FETCH values with `mem_ready` gating as above; `reg_write`, `mem_write` and `illegal` are 0.
- A reset asserted mid-instruction (for example during MEMWRITE) aborts it. `mem_write` drops in the same cycle and no retire is counted.
- The first state transition happens on the first rising edge after `rst_n` is released.
- Latency with zero wait states (`mem_ready` tied high):
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type ALU: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs stay stable while waiting.
- `op` is sampled in DECODE and MEMADR only; it must be stable from the cycle after the FETCH `ir_write` until the instruction retires.

## Test plan
- Reset with `mem_ready`=1, then lw (`op`=0000011) → state sequence 0,1,2,3,4,0; `reg_write`=1 only in MEMWB with `result_src`=01; `instret` 0→1.
- sw with `mem_ready` low for 3 cycles in MEMWRITE → `mem_write` high for 4 consecutive cycles; exactly one retire counted.
- beq with `zero`=1, then beq with `zero`=0 → `pc_write`=1 in BEQ only for the first; `alu_op`=01 in both; `instret` +2.
- R-type, then addi, then jal → `alu_op`=10 in EXECR and EXECI, 00 in JAL; JAL `pc_write`=1 and goes to ALUWB; `instret` +3.
- `op`=1111111 → `illegal` pulses for one cycle in DECODE, FSM returns to FETCH, `instret` unchanged.
- Preload `instret` to all-ones (`INSTRET_W`=4) via 15 ALU instructions, then one more → `instret`=0. Assert `rst_n`=0 during MEMREAD → `state`=0 with no clock edge.
